dsp_out_stage: RTL and testbench

Output conditioning stage placed directly downstream of the DSP slice. It consumes the 48-bit `P` result and `carryout` on a valid strobe. Each result is rounded and arithmetically right-shifted, then saturated to `OUT_W` bits. Results are buffered in a small FIFO with valid/ready handshake to the consumer, because the DSP slice cannot be back-pressured.

---
 rtl/dsp_out_pkg.sv | 31 +++
 rtl/dsp_out_stage_fifo.sv | 61 ++++++
 rtl/dsp_out_stage.sv | 95 +++++++++
 tb/tb_dsp_out_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_out_pkg.sv
// Shared constants, FIFO entry type and saturation-limit helper for the
// DSP output conditioning stage.
package dsp_out_pkg;

   localparam int unsigned INT_W     = 50;
   localparam int unsigned MAX_OUT_W = 48;

   typedef struct packed {
      logic                 sat;
      logic [MAX_OUT_W-1:0] data;
   } entry_t;

   typedef struct packed {
      logic [INT_W-1:0] hi;
      logic [INT_W-1:0] lo;
   } sat_lim_t;

   // Two's-complement bit patterns of the clamp limits for an out_w-bit result
   function automatic sat_lim_t sat_limits(input int unsigned out_w, input logic is_signed);
      sat_lim_t lim;
      if (is_signed) begin
         lim.hi = (INT_W'(1) << (out_w - 1)) - INT_W'(1);
         lim.lo = -(INT_W'(1) << (out_w - 1));
      end else begin
         lim.hi = (INT_W'(1) << out_w) - INT_W'(1);
         lim.lo = '0;
      end
      return lim;
   endfunction

endpackage

// File: rtl/dsp_out_stage_fifo.sv
// First-word fall-through FIFO; a full FIFO still accepts a write when the
// head is popped in the same cycle.
module out_fifo
   import dsp_out_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   input  entry_t                   wr_entry,
   output logic                     wr_drop_c,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output entry_t                   rd_entry_c,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push_c;
   logic               pop_c;
   logic [CNT_W-1:0]   count_nxt_c;

   always_comb begin
      pop_c       = rd_valid && rd_ready;
      push_c      = wr_valid && ((count < CNT_W'(DEPTH)) || pop_c);
      wr_drop_c   = wr_valid && !push_c;
      count_nxt_c = count;
      case ({push_c, pop_c})
         2'b10:   count_nxt_c = count + CNT_W'(1);
         2'b01:   count_nxt_c = count - CNT_W'(1);
         default: count_nxt_c = count;
      endcase
      rd_entry_c = rd_valid ? mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_nxt_c;
         rd_valid <= (count_nxt_c != '0);
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/dsp_out_stage.sv
// Rounds, shifts and saturates DSP slice results, then buffers them in a
// small FWFT FIFO towards a back-pressuring consumer.
module dsp_out_stage
   import dsp_out_pkg::*;
#(
   parameter int unsigned OUT_W  = 18,
   parameter int unsigned SHIFT  = 17,
   parameter int unsigned ROUND  = 1,
   parameter int unsigned SIGNED = 1,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [47:0]              P,
   input  logic                     carryout,
   input  logic                     p_valid,
   output logic [OUT_W-1:0]         y,
   output logic                     y_sat,
   output logic                     y_valid,
   input  logic                     y_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop_sticky,
   output logic                     sat_sticky,
   input  logic                     clr_sticky
);

   localparam sat_lim_t LIM = sat_limits(OUT_W, SIGNED != 0);
   localparam logic signed [INT_W-1:0] SAT_HI = $signed(LIM.hi);
   localparam logic signed [INT_W-1:0] SAT_LO = $signed(LIM.lo);
   localparam logic signed [INT_W-1:0] RND =
      (ROUND != 0 && SHIFT > 0) ? (INT_W'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

   logic signed [INT_W-1:0] v_c;
   logic signed [INT_W-1:0] r_c;
   logic signed [INT_W-1:0] s_c;
   logic [OUT_W-1:0]        q_c;
   logic                    sat_c;
   entry_t                  stg;
   logic                    stg_valid;
   entry_t                  head_c;
   logic                    drop_c;
   logic                    unused_head_bits;

   // Widen to 50 bits so the rounding add cannot overflow
   always_comb begin
      if (SIGNED != 0) v_c = INT_W'($signed(P));
      else             v_c = INT_W'({carryout, P});
      r_c   = v_c + RND;
      s_c   = r_c >>> SHIFT;
      sat_c = 1'b0;
      q_c   = s_c[OUT_W-1:0];
      if (s_c > SAT_HI) begin
         q_c   = SAT_HI[OUT_W-1:0];
         sat_c = 1'b1;
      end else if (s_c < SAT_LO) begin
         q_c   = SAT_LO[OUT_W-1:0];
         sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg         <= '0;
         stg_valid   <= 1'b0;
         sat_sticky  <= 1'b0;
         drop_sticky <= 1'b0;
      end else begin
         stg_valid <= p_valid;
         if (p_valid) stg <= '{sat: sat_c, data: MAX_OUT_W'(q_c)};
         // A set event in the same cycle as a clear wins
         if (p_valid && sat_c) sat_sticky <= 1'b1;
         else if (clr_sticky)  sat_sticky <= 1'b0;
         if (drop_c)          drop_sticky <= 1'b1;
         else if (clr_sticky) drop_sticky <= 1'b0;
      end
   end

   out_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (stg_valid),
      .wr_entry   (stg),
      .wr_drop_c  (drop_c),
      .rd_ready   (y_ready),
      .rd_valid   (y_valid),
      .rd_entry_c (head_c),
      .count      (count)
   );

   // Head is combinational from the FIFO memory; upper data bits stay zero
   assign y                = head_c.data[OUT_W-1:0];
   assign y_sat            = head_c.sat;
   assign unused_head_bits = ^head_c.data;

endmodule

// File: tb/tb_dsp_out_stage.sv
// Scoreboard bench for dsp_out_stage: default, truncating and unsigned variants
// share one stimulus stream and are checked against a behavioural model.
module tb_dsp_out_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] P;
   logic        carryout;
   logic        p_valid;
   logic        y_ready;
   logic        clr_sticky;

   logic [17:0] y0, y1, y2;
   logic        s0, s1, s2;
   logic        v0, v1, v2;
   logic [2:0]  c0, c1, c2;
   logic        d0, d1, d2;
   logic        ss0, ss1, ss2;

   logic [18:0] q0[$];
   logic [18:0] q1[$];
   logic [18:0] q2[$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dsp_out_stage u_dut (
      .clk(clk), .rst(rst), .P(P), .carryout(carryout), .p_valid(p_valid),
      .y(y0), .y_sat(s0), .y_valid(v0), .y_ready(y_ready), .count(c0),
      .drop_sticky(d0), .sat_sticky(ss0), .clr_sticky(clr_sticky));

   dsp_out_stage #(.ROUND(0)) u_trunc (
      .clk(clk), .rst(rst), .P(P), .carryout(carryout), .p_valid(p_valid),
      .y(y1), .y_sat(s1), .y_valid(v1), .y_ready(y_ready), .count(c1),
      .drop_sticky(d1), .sat_sticky(ss1), .clr_sticky(clr_sticky));

   dsp_out_stage #(.SIGNED(0)) u_uns (
      .clk(clk), .rst(rst), .P(P), .carryout(carryout), .p_valid(p_valid),
      .y(y2), .y_sat(s2), .y_valid(v2), .y_ready(y_ready), .count(c2),
      .drop_sticky(d2), .sat_sticky(ss2), .clr_sticky(clr_sticky));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: {sat, y} for OUT_W=18, SHIFT=17
   function automatic logic [18:0] model(input logic [47:0] p, input logic co,
                                         input bit rnd, input bit sgn);
      logic signed [49:0] v;
      logic signed [49:0] s;
      if (sgn) v = {{2{p[47]}}, p};
      else     v = {1'b0, co, p};
      if (rnd) v = v + 50'sd65536;
      s = v >>> 17;
      if (sgn) begin
         if (s > 50'sd131071)  return {1'b1, 18'h1FFFF};
         if (s < -50'sd131072) return {1'b1, 18'h20000};
      end else if (s > 50'sd262143) begin
         return {1'b1, 18'h3FFFF};
      end
      return {1'b0, s[17:0]};
   endfunction

   task automatic push(input logic [47:0] p, input logic co, input bit dropped);
      P        = p;
      carryout = co;
      p_valid  = 1'b1;
      if (!dropped) begin
         q0.push_back(model(p, co, 1'b1, 1'b1));
         q1.push_back(model(p, co, 1'b0, 1'b1));
         q2.push_back(model(p, co, 1'b1, 1'b0));
      end
      @(posedge clk); #1;
      p_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      y_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
         step();
      end
      chk("drain_left", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      chk("drain_valid", 32'({v0, v1, v2}), 32'd0);
   endtask

   task automatic clr_pulse();
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
   endtask

   // Scoreboard: compare head word on every pop
   always @(negedge clk) begin
      if (!rst && y_ready) begin
         if (v0) begin
            if (q0.size() == 0) chk("unexp_dut", 32'd1, 32'd0);
            else chk("y_dut", 32'({s0, y0}), 32'(q0.pop_front()));
         end
         if (v1) begin
            if (q1.size() == 0) chk("unexp_trunc", 32'd1, 32'd0);
            else chk("y_trunc", 32'({s1, y1}), 32'(q1.pop_front()));
         end
         if (v2) begin
            if (q2.size() == 0) chk("unexp_uns", 32'd1, 32'd0);
            else chk("y_uns", 32'({s2, y2}), 32'(q2.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b1; P = '0; carryout = 1'b0; p_valid = 1'b0;
      y_ready = 1'b0; clr_sticky = 1'b0;
      #1;
      chk("rst_valid", 32'(v0), 32'd0);
      chk("rst_count", 32'(c0), 32'd0);
      chk("rst_y", 32'(y0), 32'd0);
      chk("rst_stickies", 32'({d0, ss0}), 32'd0);
      step(); step();
      rst = 1'b0;

      // Exact shift and two-cycle latency
      push(48'h0000_0006_0000, 1'b0, 1'b0);
      chk("lat_k1_valid", 32'(v0), 32'd0);
      step();
      chk("lat_k2_valid", 32'(v0), 32'd1);
      chk("exact_y", 32'({s0, y0}), 32'd3);
      drain();

      // Rounding versus truncation, back to back with ready held high
      y_ready = 1'b1;
      push(48'h0000_000B_0000, 1'b0, 1'b0);
      push(48'hFFFF_FFFF_0000, 1'b0, 1'b0);
      push(48'h0000_0003_0000, 1'b0, 1'b0);
      drain();

      // Saturation at both rails, plus carryout for the unsigned variant
      push(48'h7FFF_FFFF_FFFF, 1'b0, 1'b0);
      push(48'h8000_0000_0000, 1'b0, 1'b0);
      push(48'h0000_0000_0000, 1'b1, 1'b0);
      drain();
      chk("sat_sticky_set", 32'({ss0, ss1, ss2}), 32'b111);
      chk("no_drop_yet", 32'(d0), 32'd0);
      clr_pulse();
      chk("sat_sticky_clr", 32'(ss0), 32'd0);

      // Overflow: fifth word is discarded
      y_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push(48'(i) << 17, 1'b0, i == 5);
      step(); step();
      chk("ovf_count", 32'(c0), 32'd4);
      chk("ovf_drop", 32'({d0, d1, d2}), 32'b111);
      drain();
      chk("drop_held", 32'(d0), 32'd1);
      clr_pulse();
      chk("drop_clr", 32'(d0), 32'd0);

      // Full FIFO accepts a write when popped in the same cycle
      y_ready = 1'b0;
      for (int i = 10; i <= 13; i++) push(48'(i) << 17, 1'b0, 1'b0);
      step();
      chk("full_count", 32'(c0), 32'd4);
      push(48'(14) << 17, 1'b0, 1'b0);
      y_ready = 1'b1;
      step();
      y_ready = 1'b0;
      chk("fullpop_count", 32'(c0), 32'd4);
      chk("fullpop_drop", 32'(d0), 32'd0);
      drain();

      // Asynchronous reset mid-stream discards buffered words
      y_ready = 1'b0;
      for (int i = 20; i <= 22; i++) push(48'(i) << 17, 1'b0, 1'b0);
      step();
      chk("pre_rst_count", 32'(c0), 32'd3);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(v0), 32'd0);
      chk("mid_rst_count", 32'(c0), 32'd0);
      chk("mid_rst_y", 32'(y0), 32'd0);
      q0.delete(); q1.delete(); q2.delete();
      step();
      rst = 1'b0;
      push(48'(30) << 17, 1'b0, 1'b0);
      chk("post_rst_k1", 32'(v0), 32'd0);
      step();
      chk("post_rst_k2", 32'(v0), 32'd1);
      chk("post_rst_y", 32'(y0), 32'd30);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
